// File: rtl/apb_slave_regfile.sv
// APB slave register file: read-only ID at index 0, wait states, decode slave error,
// sticky protocol-violation flag. Define APB_PSTRB_EN to add the p_strb byte-strobe port.
module apb_slave_regfile #(
  parameter int unsigned        A_WIDTH     = 8,
  parameter int unsigned        D_WIDTH     = 32,
  parameter int unsigned        NUM_REGS    = 16,
  parameter int unsigned        WAIT_CYCLES = 0,
  parameter logic [D_WIDTH-1:0] RESET_VAL   = 'h12,
  parameter logic [D_WIDTH-1:0] ID_VAL      = 'hA5B1
) (
  input  logic                 p_clk,
  input  logic                 p_rst,
  input  logic                 p_sel,
  input  logic                 p_enable,
  input  logic                 p_write,
  input  logic [A_WIDTH-1:0]   p_addr,
  input  logic [D_WIDTH-1:0]   wr_data,
`ifdef APB_PSTRB_EN
  input  logic [D_WIDTH/8-1:0] p_strb,
`endif
  output logic [D_WIDTH-1:0]   rd_data,
  output logic                 p_ready,
  output logic                 p_slverr,
  output logic                 prot_err
);

  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int unsigned NB = D_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    W_PHASE = 2'd2,
    R_PHASE = 2'd3
  } state_t;

  state_t               state;
  logic [CW-1:0]        wait_cnt;
  logic [A_WIDTH-1:0]   lat_addr;
  logic                 lat_write;
  logic [D_WIDTH-1:0]   lat_wdata;
  logic [NB-1:0]        wr_mask;
  logic [D_WIDTH-1:0]   regs [1:NUM_REGS-1];
  logic [31:0]          idx;
  logic                 in_range;
  logic                 slverr;
  logic                 setup_req;
  logic                 do_latch;
  logic                 violation;
  logic [D_WIDTH-1:0]   rd_val;

`ifdef APB_PSTRB_EN
  logic [NB-1:0]        lat_strb;
  assign wr_mask = lat_strb;
`else
  assign wr_mask = '1;
`endif

  assign idx       = 32'(lat_addr);
  assign in_range  = idx < NUM_REGS;
  assign slverr    = !in_range || (lat_write && (idx == 0));
  assign p_ready   = ((state == W_PHASE) || (state == R_PHASE)) && (wait_cnt == CW'(WAIT_CYCLES));
  assign p_slverr  = p_ready && slverr;
  assign setup_req = p_sel && !p_enable;
  // A new setup is accepted from IDLE or on the completing edge (back-to-back).
  assign do_latch  = setup_req && ((state == IDLE) || p_ready);
  assign violation = (p_addr != lat_addr) || (p_write != lat_write) || !p_sel || !p_enable;

  always_comb begin
    rd_val = RESET_VAL;
    if (idx == 0) rd_val = ID_VAL;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (idx == i) rd_val = regs[i];
    end
  end

  always_ff @(posedge p_clk) begin
    if (p_rst) begin
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
`ifdef APB_PSTRB_EN
      lat_strb  <= '0;
`endif
    end else if (do_latch) begin
      lat_addr  <= p_addr;
      lat_write <= p_write;
      lat_wdata <= wr_data;
`ifdef APB_PSTRB_EN
      lat_strb  <= p_strb;
`endif
    end
  end

  always_ff @(posedge p_clk) begin
    if (p_rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      rd_data  <= RESET_VAL;
      prot_err <= 1'b0;
      for (int unsigned i = 1; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      case (state)
        IDLE: begin
          if (setup_req) state <= SETUP;
          else if (p_sel) prot_err <= 1'b1;
        end
        SETUP: begin
          if (!p_sel) begin
            state <= IDLE;
          end else if (p_enable) begin
            state    <= lat_write ? W_PHASE : R_PHASE;
            wait_cnt <= '0;
            if (!lat_write) rd_data <= rd_val;
          end
        end
        W_PHASE, R_PHASE: begin
          if (!p_ready) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (violation) prot_err <= 1'b1;
          end else begin
            if ((state == W_PHASE) && !slverr) begin
              for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (idx == i) begin
                  for (int unsigned b = 0; b < NB; b++) begin
                    if (wr_mask[b]) regs[i][8*b +: 8] <= lat_wdata[8*b +: 8];
                  end
                end
              end
            end
            state <= setup_req ? SETUP : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
